// File: rtl/ql_mult_acc_pkg.sv
// Shared types and constants for the QLAL4S3 multiply-accumulate wrapper.
package ql_mult_acc_pkg;

  localparam int ACC_WIDTH_DEF = 80;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [1:0] VM_NONE = 2'b00;
  localparam logic [1:0] VM_32   = 2'b01;
  localparam logic [1:0] VM_DUAL = 2'b11;

endpackage

// File: rtl/ql_acc_add.sv
// Signed W-bit adder with optional clamp to the signed range on overflow.
module ql_acc_add #(
  parameter int W      = 40,
  parameter bit SAT_EN = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;
  logic         overflow;

  always_comb begin
    // NOTE: every output gets a value before any conditional, so no latch is inferred.
    raw      = a + b;
    overflow = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    sum      = raw;
    ovf      = 1'b0;
    if (SAT_EN && overflow) begin
      // Both operands share a sign on overflow; clamp toward that sign.
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/ql_mult_acc_seq.sv
// Stream front/back end for the QLAL4S3 hard multiplier: one 32x32 or two 16x16 MAC lanes.
// Define QL_MULT_ACC_SAT_EN to saturate the accumulator lanes instead of wrapping.
module ql_mult_acc_seq
  import ql_mult_acc_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic                 in_last,
  input  logic                 in_mode32,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_sat,
  output logic [31:0]          Amult,
  output logic [31:0]          Bmult,
  output logic [1:0]           Valid_mult,
  output logic                 sel_mul_32x32,
  input  logic [63:0]          Cmult
);

  localparam int HW = ACC_WIDTH / 2;
`ifdef QL_MULT_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t               state;
  logic                 mode_q;
  logic [63:0]          prod_q;
  logic                 prod_vld;
  logic [ACC_WIDTH-1:0] acc_q;

  logic hs_in, first_beat, beat_mode;
  assign hs_in      = in_valid && in_ready;
  assign first_beat = hs_in && (state == IDLE);
  // The frame mode is only taken from the bus on the first beat.
  assign beat_mode  = (state == IDLE) ? in_mode32 : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (hs_in) begin
            if (in_last) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (hs_in && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // Leave once neither pipeline stage holds a product still to be added.
          if ((Valid_mult == VM_NONE) && !prod_vld) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Amult      <= '0;
      Bmult      <= '0;
      Valid_mult <= VM_NONE;
      mode_q     <= 1'b0;
    end else begin
      Valid_mult <= VM_NONE;
      if (hs_in) begin
        Amult      <= in_a;
        Bmult      <= in_b;
        Valid_mult <= beat_mode ? VM_32 : VM_DUAL;
        if (state == IDLE) mode_q <= in_mode32;
      end
    end
  end

  assign sel_mul_32x32 = mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= (Valid_mult != VM_NONE);
      if (Valid_mult != VM_NONE) prod_q <= Cmult;
    end
  end

  logic [ACC_WIDTH-1:0] prod_full, sum_full;
  logic [HW-1:0]        prod_l0, prod_l1, sum_l0, sum_l1;
  logic                 ovf_full, ovf_l0, ovf_l1;

  assign prod_full = ACC_WIDTH'($signed(prod_q));
  assign prod_l0   = HW'($signed(prod_q[31:0]));
  assign prod_l1   = HW'($signed(prod_q[63:32]));

  ql_acc_add #(.W(ACC_WIDTH), .SAT_EN(SAT_EN)) u_add_full (
    .a(acc_q), .b(prod_full), .sum(sum_full), .ovf(ovf_full)
  );
  ql_acc_add #(.W(HW), .SAT_EN(SAT_EN)) u_add_l0 (
    .a(acc_q[HW-1:0]), .b(prod_l0), .sum(sum_l0), .ovf(ovf_l0)
  );
  ql_acc_add #(.W(HW), .SAT_EN(SAT_EN)) u_add_l1 (
    .a(acc_q[ACC_WIDTH-1:HW]), .b(prod_l1), .sum(sum_l1), .ovf(ovf_l1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (first_beat) begin
      acc_q     <= '0;
      out_count <= CNT_WIDTH'(1);
      out_sat   <= 1'b0;
    end else begin
      if (hs_in && (out_count != '1)) out_count <= out_count + CNT_WIDTH'(1);
      if (prod_vld) begin
        acc_q   <= mode_q ? sum_full : {sum_l1, sum_l0};
        out_sat <= out_sat | (mode_q ? ovf_full : (ovf_l0 | ovf_l1));
      end
    end
  end

  // The accumulator only changes while a frame is in flight, so it is stable in HOLD.
  assign out_acc = acc_q;

endmodule
